// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 sequencer: state encoding, CP0 register
// selects and the default interrupt handler address.
package cp0_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAVE   = 2'd1,
    ST_VECTOR = 2'd2,
    ST_RETURN = 2'd3
  } cp0_state_e;

  localparam logic [4:0] CP0_SEL_SR    = 5'd12;
  localparam logic [4:0] CP0_SEL_CAUSE = 5'd13;
  localparam logic [4:0] CP0_SEL_EPC   = 5'd14;
  localparam logic [4:0] CP0_SEL_PRID  = 5'd15;

  // Word address [31:2]; byte address 0x4180.
  localparam logic [29:0] DEFAULT_HANDLER_PC = 30'h0000_1060;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; cleared asynchronously by rst_n.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cp0_seq.sv
// CP0 sequencer: takes interrupts at retire boundaries, writes EPC, vectors
// to the handler, executes ERET and steers MTC0/MFC0 onto the CP0 port.
module cp0_seq
  import cp0_pkg::*;
#(
  parameter logic [29:0] HANDLER_PC = DEFAULT_HANDLER_PC,
  parameter logic [4:0]  SEL_EPC    = CP0_SEL_EPC,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_done,
  input  logic [29:0]      next_pc,
  input  logic             is_mtc0,
  input  logic             is_mfc0,
  input  logic             is_eret,
  input  logic [4:0]       sel_in,
  input  logic             int_req,
  input  logic [29:0]      epc,
  output logic [4:0]       cp0_sel,
  output logic             cp0_wen,
  output logic [29:0]      cp0_pc,
  output logic             exl_set,
  output logic             exl_clr,
  output logic             pc_redirect,
  output logic [29:0]      redirect_pc,
  output logic             stall,
  output logic [CNT_W-1:0] irq_count
);

  cp0_state_e  state_q, state_d;
  logic [29:0] saved_pc_q, saved_pc_d;

  logic stall_q;
  logic exl_set_q;
  logic exl_clr_q;
  logic pc_redirect_q;

  // ERET outranks MTC0, which in turn masks interrupt acceptance for a cycle.
  always_comb begin
    state_d    = state_q;
    saved_pc_d = saved_pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_done) begin
          if (is_eret) begin
            state_d = ST_RETURN;
          end else if (is_mtc0) begin
            state_d = ST_IDLE;
          end else if (int_req) begin
            saved_pc_d = next_pc;
            state_d    = ST_SAVE;
          end
        end
      end
      ST_SAVE:   state_d = ST_VECTOR;
      ST_VECTOR: state_d = ST_IDLE;
      ST_RETURN: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      saved_pc_q    <= '0;
      stall_q       <= 1'b0;
      exl_set_q     <= 1'b0;
      exl_clr_q     <= 1'b0;
      pc_redirect_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      saved_pc_q    <= saved_pc_d;
      stall_q       <= (state_d != ST_IDLE);
      exl_set_q     <= (state_d == ST_SAVE);
      exl_clr_q     <= (state_d == ST_RETURN);
      pc_redirect_q <= (state_d == ST_VECTOR) || (state_d == ST_RETURN);
    end
  end

  // IDLE port steering is combinational, so it is gated by rst_n to keep
  // every output quiet while reset is held.
  always_comb begin
    cp0_sel = '0;
    cp0_wen = 1'b0;
    if (exl_set_q) begin
      cp0_sel = SEL_EPC;
      cp0_wen = 1'b1;
    end else if (rst_n && (state_q == ST_IDLE)) begin
      if (instr_done && is_mtc0 && !is_eret) begin
        cp0_sel = sel_in;
        cp0_wen = 1'b1;
      end else if (is_mfc0 && !(instr_done && is_eret)) begin
        cp0_sel = sel_in;
      end
    end
  end

  always_comb begin
    redirect_pc = '0;
    if (pc_redirect_q) begin
      redirect_pc = exl_clr_q ? epc : HANDLER_PC;
    end
  end

  assign cp0_pc      = saved_pc_q;
  assign exl_set     = exl_set_q;
  assign exl_clr     = exl_clr_q;
  assign pc_redirect = pc_redirect_q;
  assign stall       = stall_q;

  sat_counter #(
    .W(CNT_W)
  ) u_irq_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (exl_set_q),
    .count(irq_count)
  );

endmodule

// File: tb/tb_cp0_seq.sv
// Directed bench for cp0_seq: one table row per cycle, plus hand-written
// reset-mid-SAVE and counter saturation sequences.
module tb_cp0_seq;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             instr_done;
  logic [29:0]      next_pc;
  logic             is_mtc0;
  logic             is_mfc0;
  logic             is_eret;
  logic [4:0]       sel_in;
  logic             int_req;
  logic [29:0]      epc;
  logic [4:0]       cp0_sel;
  logic             cp0_wen;
  logic [29:0]      cp0_pc;
  logic             exl_set;
  logic             exl_clr;
  logic             pc_redirect;
  logic [29:0]      redirect_pc;
  logic             stall;
  logic [CNT_W-1:0] irq_count;

  int checks   = 0;
  int failures = 0;

  cp0_seq #(
    .HANDLER_PC(30'h0000_1060),
    .SEL_EPC   (5'd14),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_done (instr_done),
    .next_pc    (next_pc),
    .is_mtc0    (is_mtc0),
    .is_mfc0    (is_mfc0),
    .is_eret    (is_eret),
    .sel_in     (sel_in),
    .int_req    (int_req),
    .epc        (epc),
    .cp0_sel    (cp0_sel),
    .cp0_wen    (cp0_wen),
    .cp0_pc     (cp0_pc),
    .exl_set    (exl_set),
    .exl_clr    (exl_clr),
    .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .irq_count  (irq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        done;
    logic [29:0] npc;
    logic        mtc0;
    logic        mfc0;
    logic        eret;
    logic [4:0]  sel;
    logic        irq;
    logic [29:0] epc_v;
    logic [4:0]  e_sel;
    logic        e_wen;
    logic [29:0] e_pc;
    logic        e_set;
    logic        e_clr;
    logic        e_redir;
    logic [29:0] e_rpc;
    logic        e_stall;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(string n, logic done, logic [29:0] npc, logic mtc0, logic mfc0,
                               logic eret, logic [4:0] sel, logic irq, logic [29:0] epc_v,
                               logic [4:0] e_sel, logic e_wen, logic [29:0] e_pc, logic e_set,
                               logic e_clr, logic e_redir, logic [29:0] e_rpc, logic e_stall,
                               logic [1:0] e_cnt);
    vec_t v;
    v.name = n; v.done = done; v.npc = npc; v.mtc0 = mtc0; v.mfc0 = mfc0; v.eret = eret;
    v.sel = sel; v.irq = irq; v.epc_v = epc_v;
    v.e_sel = e_sel; v.e_wen = e_wen; v.e_pc = e_pc; v.e_set = e_set; v.e_clr = e_clr;
    v.e_redir = e_redir; v.e_rpc = e_rpc; v.e_stall = e_stall; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [29:0] act, input logic [29:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    instr_done = v.done;
    next_pc    = v.npc;
    is_mtc0    = v.mtc0;
    is_mfc0    = v.mfc0;
    is_eret    = v.eret;
    sel_in     = v.sel;
    int_req    = v.irq;
    epc        = v.epc_v;
  endtask

  task automatic checkOutput(input vec_t v);
    chk({v.name, ".cp0_sel"},     30'(cp0_sel),     30'(v.e_sel));
    chk({v.name, ".cp0_wen"},     30'(cp0_wen),     30'(v.e_wen));
    chk({v.name, ".cp0_pc"},      cp0_pc,           v.e_pc);
    chk({v.name, ".exl_set"},     30'(exl_set),     30'(v.e_set));
    chk({v.name, ".exl_clr"},     30'(exl_clr),     30'(v.e_clr));
    chk({v.name, ".pc_redirect"}, 30'(pc_redirect), 30'(v.e_redir));
    chk({v.name, ".redirect_pc"}, redirect_pc,      v.e_rpc);
    chk({v.name, ".stall"},       30'(stall),       30'(v.e_stall));
    chk({v.name, ".irq_count"},   30'(irq_count),   30'(v.e_cnt));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled 3 later.
  task automatic runVec(input vec_t v);
    applyStimulus(v);
    #3;
    checkOutput(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //              name           done npc       mtc0 mfc0 eret sel irq epc        | sel wen pc        set clr rdr rpc          stl cnt
    vecs.push_back(mkv("idle0",     0, 30'h0,   0, 0, 0, 5'd0,  0, 30'h0,    5'd0,  0, 30'h0,   0, 0, 0, 30'h0,     0, 2'd0));
    vecs.push_back(mkv("mfc0",      0, 30'h0,   0, 1, 0, 5'd13, 0, 30'h0,    5'd13, 0, 30'h0,   0, 0, 0, 30'h0,     0, 2'd0));
    vecs.push_back(mkv("irq_noret", 0, 30'h0,   0, 0, 0, 5'd0,  1, 30'h0,    5'd0,  0, 30'h0,   0, 0, 0, 30'h0,     0, 2'd0));
    vecs.push_back(mkv("irq_take",  1, 30'h100, 0, 0, 0, 5'd0,  1, 30'h0,    5'd0,  0, 30'h0,   0, 0, 0, 30'h0,     0, 2'd0));
    vecs.push_back(mkv("save1",     1, 30'h7,   0, 0, 0, 5'd0,  1, 30'h0,    5'd14, 1, 30'h100, 1, 0, 0, 30'h0,     1, 2'd0));
    vecs.push_back(mkv("vector1",   1, 30'h9,   0, 0, 0, 5'd0,  1, 30'h0,    5'd0,  0, 30'h100, 0, 0, 1, 30'h1060,  1, 2'd1));
    vecs.push_back(mkv("idle1",     0, 30'h0,   0, 0, 0, 5'd0,  0, 30'h0,    5'd0,  0, 30'h100, 0, 0, 0, 30'h0,     0, 2'd1));
    vecs.push_back(mkv("eret_irq",  1, 30'h44,  0, 0, 1, 5'd0,  1, 30'h100,  5'd0,  0, 30'h100, 0, 0, 0, 30'h0,     0, 2'd1));
    vecs.push_back(mkv("return1",   0, 30'h0,   0, 0, 0, 5'd0,  1, 30'hABC,  5'd0,  0, 30'h100, 0, 1, 1, 30'hABC,   1, 2'd1));
    vecs.push_back(mkv("irq_post",  1, 30'h200, 0, 0, 0, 5'd0,  1, 30'h0,    5'd0,  0, 30'h100, 0, 0, 0, 30'h0,     0, 2'd1));
    vecs.push_back(mkv("save2",     0, 30'h0,   0, 0, 0, 5'd0,  0, 30'h0,    5'd14, 1, 30'h200, 1, 0, 0, 30'h0,     1, 2'd1));
    vecs.push_back(mkv("vector2",   0, 30'h0,   0, 0, 0, 5'd0,  0, 30'h0,    5'd0,  0, 30'h200, 0, 0, 1, 30'h1060,  1, 2'd2));
    vecs.push_back(mkv("mtc0_irq",  1, 30'h300, 1, 0, 0, 5'd12, 1, 30'h0,    5'd12, 1, 30'h200, 0, 0, 0, 30'h0,     0, 2'd2));
    vecs.push_back(mkv("irq_next",  1, 30'h304, 0, 0, 0, 5'd0,  1, 30'h0,    5'd0,  0, 30'h200, 0, 0, 0, 30'h0,     0, 2'd2));
    vecs.push_back(mkv("save3",     0, 30'h0,   0, 0, 0, 5'd0,  0, 30'h0,    5'd14, 1, 30'h304, 1, 0, 0, 30'h0,     1, 2'd2));
    vecs.push_back(mkv("vector3",   0, 30'h0,   0, 0, 0, 5'd0,  1, 30'h0,    5'd0,  0, 30'h304, 0, 0, 1, 30'h1060,  1, 2'd3));
    vecs.push_back(mkv("eret_mtc0", 1, 30'h0,   1, 0, 1, 5'd12, 0, 30'h55,   5'd0,  0, 30'h304, 0, 0, 0, 30'h0,     0, 2'd3));
    vecs.push_back(mkv("return2",   0, 30'h0,   0, 0, 0, 5'd0,  0, 30'h55,   5'd0,  0, 30'h304, 0, 1, 1, 30'h55,    1, 2'd3));
    vecs.push_back(mkv("idle2",     0, 30'h0,   0, 0, 0, 5'd0,  0, 30'h0,    5'd0,  0, 30'h304, 0, 0, 0, 30'h0,     0, 2'd3));
    // Fourth take with CNT_W=2: the counter must hold at 3.
    vecs.push_back(mkv("irq_sat",   1, 30'h3F0, 0, 0, 0, 5'd0,  1, 30'h0,    5'd0,  0, 30'h304, 0, 0, 0, 30'h0,     0, 2'd3));
    vecs.push_back(mkv("save4",     0, 30'h0,   0, 0, 0, 5'd0,  0, 30'h0,    5'd14, 1, 30'h3F0, 1, 0, 0, 30'h0,     1, 2'd3));
    vecs.push_back(mkv("vector4",   0, 30'h0,   0, 0, 0, 5'd0,  0, 30'h0,    5'd0,  0, 30'h3F0, 0, 0, 1, 30'h1060,  1, 2'd3));
    vecs.push_back(mkv("idle_sat",  0, 30'h0,   0, 0, 0, 5'd0,  0, 30'h0,    5'd0,  0, 30'h3F0, 0, 0, 0, 30'h0,     0, 2'd3));

    // Reset held with a live MFC0 on the inputs: every output must stay 0.
    rst_n = 1'b0;
    applyStimulus(mkv("rst", 1, 30'h5, 0, 1, 0, 5'd5, 1, 30'h9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    checkOutput(mkv("reset", 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 30'h0, 0, 0, 0, 30'h0, 0, 2'd0));
    rst_n = 1'b1;

    foreach (vecs[i]) runVec(vecs[i]);

    // Reset dropped in the middle of a SAVE cycle.
    runVec(mkv("pre_rst_take", 1, 30'h150, 0, 0, 0, 5'd0, 1, 30'h0,
               5'd0, 0, 30'h3F0, 0, 0, 0, 30'h0, 0, 2'd3));
    applyStimulus(mkv("in_save", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("mid_save.cp0_wen_before", 30'(cp0_wen), 30'd1);
    rst_n = 1'b0;
    #1;
    checkOutput(mkv("mid_save_rst", 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 30'h0, 0, 0, 0, 30'h0, 0, 2'd0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    runVec(mkv("after_rst", 0, 30'h0, 0, 0, 0, 5'd0, 0, 30'h0,
               5'd0, 0, 30'h0, 0, 0, 0, 30'h0, 0, 2'd0));
    runVec(mkv("take_post_rst", 1, 30'h88, 0, 0, 0, 5'd0, 1, 30'h0,
               5'd0, 0, 30'h0, 0, 0, 0, 30'h0, 0, 2'd0));
    runVec(mkv("save_post_rst", 0, 30'h0, 0, 0, 0, 5'd0, 0, 30'h0,
               5'd14, 1, 30'h88, 1, 0, 0, 30'h0, 1, 2'd0));
    runVec(mkv("vec_post_rst", 0, 30'h0, 0, 0, 0, 5'd0, 0, 30'h0,
               5'd0, 0, 30'h88, 0, 0, 1, 30'h1060, 1, 2'd1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
